// File: rtl/decode_issue_sequencer.sv
// decode_issue_sequencer: instruction FIFO, opcode/immediate decode and registered issue slot with load-use bubbles.
// Optional DECODE_ILLEGAL_CHECK_EN drives id_illegal_o for unmapped opcodes.
module decode_issue_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STALL_CW   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [DATA_WIDTH-1:0] if_instr_i,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [DATA_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_imm_o,
  output logic [2:0]            id_imm_sel_o,
  output logic                  id_illegal_o,
  input  logic                  ex_is_load_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  flush_i,
  output logic [STALL_CW-1:0]   stall_cnt_o
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {SEL_NONE = 3'd0, SEL_I, SEL_S, SEL_B, SEL_U, SEL_J} imm_sel_e;

  logic [2*DW-1:0]   mem_q [FIFO_DEPTH];
  logic [2*DW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              id_valid_q, id_valid_d;
  logic [DW-1:0]     id_instr_q, id_instr_d, id_pc_q, id_pc_d, id_imm_q, id_imm_d;
  logic [2:0]        id_imm_sel_q, id_imm_sel_d;
  logic              id_illegal_q, id_illegal_d;
  logic [STALL_CW-1:0] stall_q, stall_d;

  logic [DW-1:0] head_instr, head_pc, imm;
  logic [6:0]    op;
  imm_sel_e      sel;
  logic          illegal, uses_rs1, uses_rs2, hazard;
  logic          ready, slot_free, nonempty, push, advance, bubble;

  assign head_pc    = mem_q[rd_ptr_q][2*DW-1:DW];
  assign head_instr = mem_q[rd_ptr_q][DW-1:0];
  assign op         = head_instr[6:0];

  always_comb begin
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: sel = SEL_I;
      7'b0100011:             sel = SEL_S;
      7'b1100011:             sel = SEL_B;
      7'b0110111, 7'b0010111: sel = SEL_U;
      7'b1101111:             sel = SEL_J;
      default:                sel = SEL_NONE;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal = !(op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111,
                                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                7'b0110011}) || head_instr[1:0] != 2'b11;
`else
  assign illegal = 1'b0;
`endif

  assign imm = sel == SEL_I ? {{(DW-11){head_instr[31]}}, head_instr[30:20]} :
               sel == SEL_S ? {{(DW-11){head_instr[31]}}, head_instr[30:25], head_instr[11:7]} :
               sel == SEL_B ? {{(DW-12){head_instr[31]}}, head_instr[7], head_instr[30:25], head_instr[11:8], 1'b0} :
               sel == SEL_U ? {{(DW-31){head_instr[31]}}, head_instr[30:12], 12'b0} :
               sel == SEL_J ? {{(DW-20){head_instr[31]}}, head_instr[19:12], head_instr[20], head_instr[30:21], 1'b0} :
                              '0;

  // NONE covers R-type and unmapped encodings, so both sources are treated as read
  assign uses_rs1 = !(sel == SEL_U || sel == SEL_J);
  assign uses_rs2 = sel == SEL_NONE || sel == SEL_S || sel == SEL_B;
  assign hazard   = ex_is_load_i && ex_rd_i != 5'd0 &&
                    ((uses_rs1 && head_instr[19:15] == ex_rd_i) || (uses_rs2 && head_instr[24:20] == ex_rd_i));

  assign ready     = !rst_i && count_q < CW'(FIFO_DEPTH);
  assign slot_free = !id_valid_q || id_ready_i;
  assign nonempty  = count_q != '0;
  assign push      = if_valid_i && ready && !flush_i;
  assign advance   = slot_free && nonempty && !hazard && !flush_i;
  assign bubble    = slot_free && nonempty && hazard && !flush_i;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {if_pc_i, if_instr_i};
    wr_ptr_d     = flush_i ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d     = flush_i ? '0 : rd_ptr_q + PW'(advance);
    count_d      = flush_i ? '0 : count_q + CW'(push) - CW'(advance);
    id_valid_d   = !flush_i && (advance || (id_valid_q && !id_ready_i));
    id_instr_d   = flush_i ? '0 : advance ? head_instr : id_instr_q;
    id_pc_d      = flush_i ? '0 : advance ? head_pc : id_pc_q;
    id_imm_d     = flush_i ? '0 : advance ? imm : id_imm_q;
    id_imm_sel_d = flush_i ? '0 : advance ? sel : id_imm_sel_q;
    id_illegal_d = flush_i ? 1'b0 : advance ? illegal : id_illegal_q;
    stall_d      = bubble && !(&stall_q) ? stall_q + STALL_CW'(1) : stall_q;
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      id_imm_q     <= '0;
      id_imm_sel_q <= '0;
      id_illegal_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_imm_q     <= id_imm_d;
      id_imm_sel_q <= id_imm_sel_d;
      id_illegal_q <= id_illegal_d;
      stall_q      <= stall_d;
    end
  end

  assign if_ready_o   = ready;
  assign id_valid_o   = id_valid_q;
  assign id_instr_o   = id_instr_q;
  assign id_pc_o      = id_pc_q;
  assign id_imm_o     = id_imm_q;
  assign id_imm_sel_o = id_imm_sel_q;
  assign id_illegal_o = id_illegal_q;
  assign stall_cnt_o  = stall_q;
endmodule

// File: tb/tb_decode_issue_sequencer.sv
// tb_decode_issue_sequencer: decode vector table, directed corner sequences and a randomized queue-based reference model.
module tb_decode_issue_sequencer;
  logic clk = 0, rst = 1, if_valid = 0, id_ready = 0, ex_load = 0, flush = 0;
  logic if_ready, id_valid, id_illegal;
  logic [31:0] if_instr = 0, if_pc = 0, id_instr, id_pc, id_imm;
  logic [2:0] id_sel;
  logic [4:0] ex_rd = 0;
  logic [3:0] stall_cnt;
  int checks = 0, errors = 0;

  decode_issue_sequencer #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .STALL_CW(4)) dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .id_valid_o(id_valid), .id_ready_i(id_ready), .id_instr_o(id_instr),
    .id_pc_o(id_pc), .id_imm_o(id_imm), .id_imm_sel_o(id_sel), .id_illegal_o(id_illegal),
    .ex_is_load_i(ex_load), .ex_rd_i(ex_rd), .flush_i(flush), .stall_cnt_o(stall_cnt));

  always #5 clk = ~clk;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  typedef struct { logic [31:0] instr; logic [2:0] sel; logic [31:0] imm; logic ill; } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push3(input logic [31:0] base);
    for (int k = 0; k < 3; k++) begin
      if_valid = 1; if_instr = base + 32'(k) * 32'h100; if_pc = 32'h2000 + 32'(k) * 4;
      step();
    end
    if_valid = 0;
  endtask

  // reference decode from the ISA field layout, using arithmetic shifts and masks
  function automatic void ref_dec(input logic [31:0] i, output logic [2:0] s, output logic [31:0] m, output logic il);
    logic signed [31:0] si;
    logic [31:0] hi20, hi25, sg;
    si = i; hi20 = si >>> 20; hi25 = si >>> 25; sg = si >>> 31;
    il = 0; m = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin s = 1; m = hi20; end
      7'h23: begin s = 2; m = (hi25 << 5) | ((i >> 7) & 32'h1F); end
      7'h63: begin s = 3; m = (sg << 12) | (((i >> 7) & 1) << 11) | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1); end
      7'h37, 7'h17: begin s = 4; m = i & 32'hFFFFF000; end
      7'h6F: begin s = 5; m = (sg << 20) | (i & 32'h000FF000) | (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1); end
      7'h33: s = 0;
      default: begin s = 0; il = ILL_ON; end
    endcase
  endfunction

  function automatic logic ref_haz(input logic [31:0] i, input logic ld, input logic [4:0] rd);
    logic [2:0] s; logic [31:0] m; logic il;
    logic [4:0] r1, r2;
    ref_dec(i, s, m, il);
    r1 = i[19:15]; r2 = i[24:20];
    return ld && rd != 0 && ((s != 4 && s != 5 && r1 == rd) || ((s == 0 || s == 2 || s == 3) && r2 == rd));
  endfunction

  logic [63:0] q [$];
  logic m_valid; logic [31:0] m_instr, m_pc, m_imm; logic [2:0] m_sel; logic m_ill; logic [3:0] m_stall;
  logic [6:0] ops [12];

  initial begin
    vt[0] = '{32'hFFF12083, 3'd1, 32'hFFFFFFFF, 1'b0};
    vt[1] = '{32'hFFFFF0EF, 3'd5, 32'hFFFFFFFE, 1'b0};
    vt[2] = '{32'h123450B7, 3'd4, 32'h12345000, 1'b0};
    vt[3] = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 1'b0};
    vt[4] = '{32'h00000463, 3'd3, 32'h00000008, 1'b0};
    vt[5] = '{32'h00728333, 3'd0, 32'h00000000, 1'b0};
    vt[6] = '{32'h00001017, 3'd4, 32'h00001000, 1'b0};
    vt[7] = '{32'h80008067, 3'd1, 32'hFFFFF800, 1'b0};
    vt[8] = '{32'h0000007F, 3'd0, 32'h00000000, ILL_ON};
    vt[9] = '{32'h00000000, 3'd0, 32'h00000000, ILL_ON};
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    step();
    chk("reset_if_ready", {31'b0, if_ready}, 0);
    chk("reset_id_valid", {31'b0, id_valid}, 0);
    chk("reset_stall", {28'b0, stall_cnt}, 0);
    chk("reset_imm", id_imm, 0);
    rst = 0;
    #1;
    chk("post_reset_if_ready", {31'b0, if_ready}, 1);

    id_ready = 1;
    for (int k = 0; k < 10; k++) begin
      if_valid = 1; if_instr = vt[k].instr; if_pc = 32'h100 + 32'(k) * 4;
      step();
      if_valid = 0;
      chk("latency_not_yet", {31'b0, id_valid}, 0);
      step();
      chk("vec_valid", {31'b0, id_valid}, 1);
      chk("vec_instr", id_instr, vt[k].instr);
      chk("vec_pc", id_pc, 32'h100 + 32'(k) * 4);
      chk("vec_sel", {29'b0, id_sel}, {29'b0, vt[k].sel});
      chk("vec_imm", id_imm, vt[k].imm);
      chk("vec_ill", {31'b0, id_illegal}, {31'b0, vt[k].ill});
      step();
      chk("vec_drain", {31'b0, id_valid}, 0);
    end

    id_ready = 0;
    push3(32'h00100013);
    chk("bp_valid", {31'b0, id_valid}, 1);
    chk("bp_head", id_instr, 32'h00100013);
    chk("bp_full_ready", {31'b0, if_ready}, 0);
    step();
    chk("bp_hold", id_instr, 32'h00100013);
    chk("bp_hold_pc", id_pc, 32'h2000);
    id_ready = 1;
    step();
    chk("bp_second", id_instr, 32'h00100113);
    chk("bp_ready_back", {31'b0, if_ready}, 1);
    step();
    chk("bp_third", id_instr, 32'h00100213);
    chk("bp_third_valid", {31'b0, id_valid}, 1);
    step();
    chk("bp_empty", {31'b0, id_valid}, 0);

    chk("lu_stall_start", {28'b0, stall_cnt}, 0);
    ex_load = 1; ex_rd = 5; if_valid = 1; if_instr = 32'h00728333;
    step();
    if_valid = 0;
    step();
    chk("lu_bubble", {31'b0, id_valid}, 0);
    chk("lu_stall_one", {28'b0, stall_cnt}, 1);
    ex_load = 0;
    step();
    chk("lu_issue", {31'b0, id_valid}, 1);
    chk("lu_instr", id_instr, 32'h00728333);
    chk("lu_stall_keep", {28'b0, stall_cnt}, 1);
    step();

    id_ready = 0;
    push3(32'h00500013);
    flush = 1;
    step();
    flush = 0;
    chk("fl_valid", {31'b0, id_valid}, 0);
    chk("fl_ready", {31'b0, if_ready}, 1);
    chk("fl_instr", id_instr, 0);
    chk("fl_stall", {28'b0, stall_cnt}, 1);
    id_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_no_issue", {31'b0, id_valid}, 0);
    end

    ex_load = 1; ex_rd = 5; if_valid = 1; if_instr = 32'h00728333;
    step();
    if_valid = 0;
    for (int k = 0; k < 20; k++) step();
    chk("sat_stall", {28'b0, stall_cnt}, 32'hF);
    chk("sat_no_issue", {31'b0, id_valid}, 0);
    ex_load = 0;
    step();
    chk("sat_issue", {31'b0, id_valid}, 1);
    rst = 1;
    step();
    chk("midrst_stall", {28'b0, stall_cnt}, 0);
    chk("midrst_valid", {31'b0, id_valid}, 0);
    chk("midrst_ready", {31'b0, if_ready}, 0);
    rst = 0;

    q.delete();
    m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_sel = 0; m_ill = 0; m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      logic [2:0] s; logic [31:0] m; logic il, rdy;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 31) == 0);
      if_valid = $urandom_range(0, 1); if_instr = ins; if_pc = $urandom;
      id_ready = ($urandom_range(0, 3) != 0);
      ex_load = $urandom_range(0, 1); ex_rd = 5'($urandom_range(0, 3));
      rdy = q.size() < 2;
      if (rst) begin
        q.delete(); m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_sel = 0; m_ill = 0; m_stall = 0;
      end else if (flush) begin
        q.delete(); m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_sel = 0; m_ill = 0;
      end else begin
        if ((!m_valid || id_ready) && q.size() > 0) begin
          if (ref_haz(q[0][31:0], ex_load, ex_rd)) begin
            m_valid = 0;
            if (m_stall != 4'hF) m_stall++;
          end else begin
            ref_dec(q[0][31:0], s, m, il);
            m_instr = q[0][31:0]; m_pc = q[0][63:32]; m_sel = s; m_imm = m; m_ill = il; m_valid = 1;
            void'(q.pop_front());
          end
        end else if (m_valid && id_ready) m_valid = 0;
        if (if_valid && rdy) q.push_back({if_pc, if_instr});
      end
      step();
      chk("rnd_if_ready", {31'b0, if_ready}, {31'b0, !rst && q.size() < 2});
      chk("rnd_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("rnd_instr", id_instr, m_instr);
      chk("rnd_pc", id_pc, m_pc);
      chk("rnd_imm", id_imm, m_imm);
      chk("rnd_sel", {29'b0, id_sel}, {29'b0, m_sel});
      chk("rnd_ill", {31'b0, id_illegal}, {31'b0, m_ill});
      chk("rnd_stall", {28'b0, stall_cnt}, {28'b0, m_stall});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
